// File: rtl/wv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wv_pkg
// Description : Shared constants and FSM state type for the wakasagi viewer
//               frame scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package wv_pkg;

  // Default geometry of the picture memory and line array
  localparam int WV_ADDR_W     = 16;
  localparam int WV_DATA_W     = 8;
  localparam int WV_LINES      = 64;
  localparam int WV_PIC_W_BYTE = 128;
  localparam int WV_PIC_COLS   = 128;
  localparam int WV_HEAD       = 0;

  // Last phase of the 256-cycle frame; the line picdata swap happens here
  localparam logic [7:0] FRAME_LAST = 8'd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wv_column_stepper.sv
`default_nettype none
// ============================================================================
// Module      : wv_column_stepper
// Description : Scroll column register. At frame end it moves the column by
//               step_size in the selected direction, wrapping modulo PIC_COLS
//               with one conditional add/subtract (step_size < PIC_COLS).
// Revision    : 1.0 - initial release
// ============================================================================
module wv_column_stepper
  import wv_pkg::*;
#(
  parameter int ADDR_W   = WV_ADDR_W,
  parameter int PIC_COLS = WV_PIC_COLS
) (
  input  logic              clk,
  input  logic              rst_N,
  input  logic              frame_end,
  input  logic              freeze,
  input  logic              dir,
  input  logic [7:0]        step_size,
  output logic [ADDR_W-1:0] column
);

  localparam logic [ADDR_W:0] C_COLS = (ADDR_W+1)'(PIC_COLS);

  logic [ADDR_W-1:0] r_column;
  logic [ADDR_W:0]   w_col;
  logic [ADDR_W:0]   w_step;
  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W:0]   w_up;
  logic [ADDR_W:0]   w_down;
  logic [ADDR_W-1:0] w_next;

  // Candidate next column: one extra bit so the sum cannot overflow before the wrap
  always_comb begin
    w_col  = {1'b0, r_column};
    w_step = (ADDR_W+1)'(step_size);
    w_sum  = w_col + w_step;
    w_up   = (w_sum >= C_COLS) ? (w_sum - C_COLS) : w_sum;
    w_down = (w_col >= w_step) ? (w_col - w_step) : (w_col + C_COLS - w_step);
    w_next = dir ? ADDR_W'(w_down) : ADDR_W'(w_up);
  end

  // Column advances once per frame unless frozen
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_column <= '0;
    end else if (frame_end && !freeze) begin
      r_column <= w_next;
    end
  end

  assign column = r_column;

endmodule
`default_nettype wire

// File: rtl/wv_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wv_scan_ctrl
// Description : Frame-level scan controller. Runs the 256-phase frame
//               counter, fetches one byte per line slot from picture memory
//               over a req/ack port each frame, delivers bytes to lines via
//               an ID-addressed load strobe, and flags late fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module wv_scan_ctrl
  import wv_pkg::*;
#(
  parameter int ADDR_W     = WV_ADDR_W,
  parameter int DATA_W     = WV_DATA_W,
  parameter int LINES      = WV_LINES,
  parameter int PIC_W_BYTE = WV_PIC_W_BYTE,
  parameter int PIC_COLS   = WV_PIC_COLS,
  parameter int HEAD       = WV_HEAD
) (
  input  logic              clk,
  input  logic              rst_N,
  input  logic              enable,
  input  logic              freeze,
  input  logic              dir,
  input  logic [7:0]        step_size,
  input  logic              overrun_clr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        counter,
  output logic              load_en,
  output logic [7:0]        load_id,
  output logic [DATA_W-1:0] load_data,
  output logic              frame_sync,
  output logic [ADDR_W-1:0] column,
  output logic              overrun,
  output logic              busy
);

  localparam logic [7:0]        C_LAST_IDX = 8'(LINES - 1);
  localparam logic [ADDR_W-1:0] C_HEAD     = ADDR_W'(HEAD);
  localparam logic [ADDR_W-1:0] C_STRIDE   = ADDR_W'(PIC_W_BYTE);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_counter;
  logic [7:0]        r_idx;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_load_en;
  logic [7:0]        r_load_id;
  logic [DATA_W-1:0] r_load_data;
  logic              r_overrun;

  logic              w_frame_end;
  logic              w_fetching;
  logic              w_req;
  logic              w_take;
  logic              w_restart;

  // Handshake qualifiers: the request is withdrawn on the frame-end cycle so
  // an ack arriving there is ignored
  assign w_frame_end = (r_counter == FRAME_LAST);
  assign w_fetching  = (r_state == FETCH);
  assign w_req       = w_fetching && !w_frame_end;
  assign w_take      = w_req && mem_ack && enable;
  assign w_restart   = !enable || (r_state == IDLE) || w_frame_end;

  // State register
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a frame end in FETCH or DONE always starts a new fetch
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = FETCH;
        FETCH: begin
          if (w_frame_end) begin
            w_state_nxt = FETCH;
          end else if (w_take && (r_idx == C_LAST_IDX)) begin
            w_state_nxt = DONE;
          end
        end
        DONE: begin
          if (w_frame_end) begin
            w_state_nxt = FETCH;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Frame phase counter, held at zero while idle
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_counter <= '0;
    end else if (!enable || (r_state == IDLE)) begin
      r_counter <= '0;
    end else begin
      r_counter <= r_counter + 8'd1;
    end
  end

  // Line index and row base advance together so no multiplier is needed
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_idx      <= '0;
      r_row_base <= C_HEAD;
    end else if (w_restart) begin
      r_idx      <= '0;
      r_row_base <= C_HEAD;
    end else if (w_take) begin
      r_idx      <= r_idx + 8'd1;
      r_row_base <= r_row_base + C_STRIDE;
    end
  end

  // Capture accepted data and strobe it to its line one cycle later
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_load_en   <= 1'b0;
      r_load_id   <= '0;
      r_load_data <= '0;
    end else begin
      r_load_en <= w_take;
      if (w_take) begin
        r_load_id   <= r_idx;
        r_load_data <= mem_rdata;
      end
    end
  end

  // Sticky overrun; a late fetch at frame end outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_overrun <= 1'b0;
    end else if (w_fetching && w_frame_end) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  wv_column_stepper #(
    .ADDR_W   (ADDR_W),
    .PIC_COLS (PIC_COLS)
  ) u_column_stepper (
    .clk       (clk),
    .rst_N     (rst_N),
    .frame_end (w_frame_end),
    .freeze    (freeze),
    .dir       (dir),
    .step_size (step_size),
    .column    (column)
  );

  assign mem_req    = w_req;
  assign mem_addr   = r_row_base + column;
  assign counter    = r_counter;
  assign load_en    = r_load_en;
  assign load_id    = r_load_id;
  assign load_data  = r_load_data;
  assign frame_sync = w_frame_end;
  assign overrun    = r_overrun;
  assign busy       = w_fetching;

endmodule
`default_nettype wire

// File: tb/tb_wv_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wv_scan_ctrl
// Description : Directed self-checking bench for wv_scan_ctrl (LINES = 4,
//               PIC_W_BYTE = 128, HEAD = 0, PIC_COLS = 128). Memory data is
//               the low address byte XOR 0xA5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wv_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_N;
  logic        enable;
  logic        freeze;
  logic        dir;
  logic [7:0]  step_size;
  logic        overrun_clr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  counter;
  logic        load_en;
  logic [7:0]  load_id;
  logic [7:0]  load_data;
  logic        frame_sync;
  logic [15:0] column;
  logic        overrun;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr[7:0] ^ 8'hA5;

  wv_scan_ctrl #(
    .ADDR_W     (16),
    .DATA_W     (8),
    .LINES      (4),
    .PIC_W_BYTE (128),
    .PIC_COLS   (128),
    .HEAD       (0)
  ) u_dut (
    .clk         (clk),
    .rst_N       (rst_N),
    .enable      (enable),
    .freeze      (freeze),
    .dir         (dir),
    .step_size   (step_size),
    .overrun_clr (overrun_clr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .counter     (counter),
    .load_en     (load_en),
    .load_id     (load_id),
    .load_data   (load_data),
    .frame_sync  (frame_sync),
    .column      (column),
    .overrun     (overrun),
    .busy        (busy)
  );

  // Advance on falling edges until counter reaches target (bounded)
  task automatic wait_counter(input logic [7:0] target);
    int n = 0;
    while (counter !== target && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (counter !== target) begin
      n_fail++;
      $display("FAIL wait_counter: timeout, counter %0d want %0d", counter, target);
    end
  endtask

  task automatic test_reset();
    rst_N = 1'b0; enable = 1'b0; freeze = 1'b0; dir = 1'b0;
    step_size = 8'd0; overrun_clr = 1'b0; mem_ack = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_N = 1'b1;
    n_checks++; if (counter !== 8'd0) begin n_fail++; $display("FAIL reset_counter: got %0d want 0", counter); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++; if (mem_addr !== 16'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
    n_checks++; if (load_en !== 1'b0) begin n_fail++; $display("FAIL reset_load_en: got %b want 0", load_en); end
    n_checks++; if ({load_id, load_data} !== 16'd0) begin n_fail++; $display("FAIL reset_load: got %h want 0", {load_id, load_data}); end
    n_checks++; if ({frame_sync, overrun, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {frame_sync, overrun, busy}); end
    n_checks++; if (column !== 16'd0) begin n_fail++; $display("FAIL reset_column: got %0d want 0", column); end
  endtask

  task automatic test_basic_fetch();
    logic [7:0] exp_data;
    enable = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      n_checks++; if (counter !== 8'(k)) begin n_fail++; $display("FAIL fetch_counter[%0d]: got %0d want %0d", k, counter, k); end
      n_checks++; if (mem_req !== (k < 4)) begin n_fail++; $display("FAIL fetch_req[%0d]: got %b want %b", k, mem_req, (k < 4)); end
      n_checks++; if (busy !== (k < 4)) begin n_fail++; $display("FAIL fetch_busy[%0d]: got %b want %b", k, busy, (k < 4)); end
      if (k < 4) begin
        n_checks++; if (mem_addr !== 16'(k * 128)) begin n_fail++; $display("FAIL fetch_addr[%0d]: got %0d want %0d", k, mem_addr, k * 128); end
      end
      n_checks++; if (load_en !== (k >= 1 && k <= 4)) begin n_fail++; $display("FAIL fetch_load_en[%0d]: got %b want %b", k, load_en, (k >= 1 && k <= 4)); end
      if (k >= 1 && k <= 4) begin
        exp_data = ((k - 1) % 2 == 0) ? 8'hA5 : 8'h25;
        n_checks++; if (load_id !== 8'(k - 1)) begin n_fail++; $display("FAIL fetch_load_id[%0d]: got %0d want %0d", k, load_id, k - 1); end
        n_checks++; if (load_data !== exp_data) begin n_fail++; $display("FAIL fetch_load_data[%0d]: got %h want %h", k, load_data, exp_data); end
      end
    end
  endtask

  task automatic test_frame_sync_step();
    step_size = 8'd3; dir = 1'b0;
    wait_counter(8'd254);
    n_checks++; if (frame_sync !== 1'b0) begin n_fail++; $display("FAIL sync_254: got %b want 0", frame_sync); end
    @(negedge clk);
    n_checks++; if (frame_sync !== 1'b1) begin n_fail++; $display("FAIL sync_255: got %b want 1", frame_sync); end
    n_checks++; if (column !== 16'd0) begin n_fail++; $display("FAIL column_before_end: got %0d want 0", column); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (mem_addr !== 16'(3 + k * 128)) begin n_fail++; $display("FAIL step_addr[%0d]: got %0d want %0d", k, mem_addr, 3 + k * 128); end
      if (k == 0) begin
        n_checks++; if (column !== 16'd3) begin n_fail++; $display("FAIL step_column: got %0d want 3", column); end
        n_checks++; if (frame_sync !== 1'b0) begin n_fail++; $display("FAIL sync_0: got %b want 0", frame_sync); end
      end
      if (k == 1) begin
        n_checks++; if (load_data !== 8'hA6) begin n_fail++; $display("FAIL step_data: got %h want a6", load_data); end
      end
    end
  endtask

  task automatic test_direction();
    // 3 -> 1 (down 2), 1 -> 126 (down 3, wraps), frozen, 126 -> 3 (up 5, wraps)
    dir = 1'b1; step_size = 8'd2;
    wait_counter(8'd255); @(negedge clk);
    n_checks++; if (column !== 16'd1) begin n_fail++; $display("FAIL dir_down2: got %0d want 1", column); end
    step_size = 8'd3;
    wait_counter(8'd255); @(negedge clk);
    n_checks++; if (column !== 16'd126) begin n_fail++; $display("FAIL dir_down_wrap: got %0d want 126", column); end
    n_checks++; if (mem_addr !== 16'd126) begin n_fail++; $display("FAIL dir_addr: got %0d want 126", mem_addr); end
    freeze = 1'b1;
    wait_counter(8'd255); @(negedge clk);
    n_checks++; if (column !== 16'd126) begin n_fail++; $display("FAIL freeze_hold: got %0d want 126", column); end
    freeze = 1'b0; dir = 1'b0; step_size = 8'd5;
    wait_counter(8'd255); @(negedge clk);
    n_checks++; if (column !== 16'd3) begin n_fail++; $display("FAIL dir_up_wrap: got %0d want 3", column); end
    freeze = 1'b1;
  endtask

  task automatic test_overrun();
    // Only two acks in the frame, so the 4-line fetch is still running at frame end
    mem_ack = 1'b0;
    wait_counter(8'd50);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++; if ({load_en, load_id, load_data} !== {1'b1, 8'd0, 8'hA6}) begin n_fail++; $display("FAIL stall_load0: got %h want 100a6", {load_en, load_id, load_data}); end
    wait_counter(8'd150);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++; if ({load_en, load_id, load_data} !== {1'b1, 8'd1, 8'h26}) begin n_fail++; $display("FAIL stall_load1: got %h want 10126", {load_en, load_id, load_data}); end
    wait_counter(8'd254);
    n_checks++; if ({overrun, busy, mem_req} !== 3'b011) begin n_fail++; $display("FAIL pre_overrun: got %b want 011", {overrun, busy, mem_req}); end
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL overrun_req_drop: got %b want 0", mem_req); end
    mem_ack = 1'b1;
    @(negedge clk);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
    n_checks++; if (load_en !== 1'b0) begin n_fail++; $display("FAIL overrun_ack_discard: got %b want 0", load_en); end
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 16'd3}) begin n_fail++; $display("FAIL overrun_restart: got %h want 10003", {mem_req, mem_addr}); end
    @(negedge clk);
    n_checks++; if ({load_en, load_id} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL overrun_new_load: got %h want 100", {load_en, load_id}); end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", overrun); end
  endtask

  task automatic test_enable_drop();
    wait_counter(8'd255);
    @(negedge clk); @(negedge clk); @(negedge clk);
    n_checks++; if ({counter, mem_addr} !== {8'd2, 16'd259}) begin n_fail++; $display("FAIL drop_pre: got %h want 020103", {counter, mem_addr}); end
    n_checks++; if ({load_en, load_id, load_data} !== {1'b1, 8'd1, 8'h26}) begin n_fail++; $display("FAIL drop_pre_load: got %h want 10126", {load_en, load_id, load_data}); end
    enable = 1'b0;
    @(negedge clk);
    n_checks++; if ({mem_req, busy, load_en} !== 3'b000) begin n_fail++; $display("FAIL drop_outputs: got %b want 000", {mem_req, busy, load_en}); end
    n_checks++; if (counter !== 8'd0) begin n_fail++; $display("FAIL drop_counter: got %0d want 0", counter); end
    @(negedge clk);
    n_checks++; if (load_en !== 1'b0) begin n_fail++; $display("FAIL drop_no_load: got %b want 0", load_en); end
    enable = 1'b1;
    @(negedge clk);
    n_checks++; if ({busy, counter, mem_addr} !== {1'b1, 8'd0, 16'd3}) begin n_fail++; $display("FAIL reenable: got %h want 1000003", {busy, counter, mem_addr}); end
    n_checks++; if (column !== 16'd3) begin n_fail++; $display("FAIL reenable_column: got %0d want 3", column); end
    @(negedge clk);
    n_checks++; if ({load_en, load_id, counter} !== {1'b1, 8'd0, 8'd1}) begin n_fail++; $display("FAIL reenable_load: got %h want 10001", {load_en, load_id, counter}); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_N = 1'b0;
    #1;
    n_checks++; if ({counter, mem_req, busy, load_en, overrun, frame_sync} !== 13'd0) begin n_fail++; $display("FAIL async_ctrl: got %h want 0", {counter, mem_req, busy, load_en, overrun, frame_sync}); end
    n_checks++; if ({load_id, load_data} !== 16'd0) begin n_fail++; $display("FAIL async_load: got %h want 0", {load_id, load_data}); end
    n_checks++; if ({mem_addr, column} !== 32'd0) begin n_fail++; $display("FAIL async_addr_col: got %h want 0", {mem_addr, column}); end
    enable = 1'b0;
    @(negedge clk);
    rst_N = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_frame_sync_step();
    test_direction();
    test_overrun();
    test_enable_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/wv_scan_ctrl.md
Name: wv_scan_ctrl

Overview:
Frame-level scan controller for the wakasagi viewer line array. Owns the 8-bit frame counter and the scroll column. Once per 256-cycle frame it fetches one byte per line slot from picture memory over a req/ack port, and delivers each byte to its line via an ID-addressed load strobe. It replaces the free-running base/offset address arithmetic: the memory may stall, scroll direction and step are programmable, and frames whose fetch does not finish in time are flagged.

Parameters:
ADDR_W, 16, picture memory address width
DATA_W, 8, memory data width (pixel byte)
LINES, 64, number of line slots fetched per frame (1..255)
PIC_W_BYTE, 128, byte stride between picture rows
PIC_COLS, 128, column count; the scroll column wraps modulo this value
HEAD, 0, base address of the picture

Ports:
clk  in  1  clock
rst_N  in  1  asynchronous active-low reset
enable  in  1  run scanning; low forces IDLE
freeze  in  1  hold the scroll column at frame end
dir  in  1  0 = column increases, 1 = column decreases
step_size  in  8  columns advanced per frame; sampled at frame end
overrun_clr  in  1  clears the overrun flag
mem_req  out  1  read request
mem_addr  out  ADDR_W  read address; stable while mem_req is high
mem_ack  in  1  read accepted; mem_rdata is valid in the same cycle
mem_rdata  in  DATA_W  read data
counter  out  8  frame phase 0..255, broadcast to the lines
load_en  out  1  one-cycle strobe: load_data targets slot load_id
load_id  out  8  target line slot
load_data  out  DATA_W  byte for the target slot
frame_sync  out  1  one-cycle pulse when counter==255 (line picdata swap)
column  out  ADDR_W  current scroll column
overrun  out  1  sticky flag: a fetch did not complete before frame end
busy  out  1  high while in FETCH

Behaviour:
- Reset values: all outputs 0, except mem_addr = HEAD. FSM state = IDLE; internal line index = 0.
- States:
  - IDLE: counter held at 0, mem_req=0. Go to FETCH on the first clock edge with enable=1.
  - FETCH: mem_req=1. mem_addr = HEAD + idx*PIC_W_BYTE + column.
  - DONE: mem_req=0. Wait for the frame to wrap.
- Row address: keep row_base in a register; add PIC_W_BYTE per line. No multiplier.
- counter increments by 1 every cycle while not in IDLE, wrapping 255 -> 0.
- Req/ack handshake: mem_req and mem_addr are held until mem_ack. On an ack in FETCH:
  - register mem_rdata into load_data;
  - next cycle assert load_en with load_id = idx;
  - increment idx.
  - On the ack for idx = LINES-1, go to DONE. Otherwise stay in FETCH with req still high, so zero-wait memory gives 1 line per cycle.
- Fetch start: idx = 0, row_base = HEAD, state FETCH at the cycle after counter==255, i.e. when counter==0. This applies from DONE, and also from FETCH in the overrun case.
- Frame end (counter==255):
  - frame_sync = 1 for that cycle.
  - Column update, unless freeze: column = (column + step_size) mod PIC_COLS if dir=0; (column - step_size) mod PIC_COLS if dir=1. Computed without a divider (single conditional add/subtract of PIC_COLS); step_size must be < PIC_COLS.
  - If the state is still FETCH: set overrun, drop mem_req, discard any ack in this cycle (no load_en is issued), and restart the fetch at counter==0. Unfetched slots keep their old data.
- mem_req may drop without an ack only on an overrun abort or when enable goes low; memory must tolerate this.
- enable low: at the next edge go to IDLE, mem_req=0, counter=0, idx=0. A pending load_en is suppressed. column and overrun are retained.
- overrun_clr clears overrun. A set and a clear in the same cycle: set wins.
- Reset mid-fetch: everything returns to reset values immediately, asynchronously.

Decomposition:
- Package wv_pkg holds:
  - ADDR_W, DATA_W, PIC_W_BYTE, HEAD, PIC_COLS defaults;
  - the state enum (IDLE, FETCH, DONE);
  - the FRAME_LAST = 255 constant.
- One sub-module, wv_column_stepper: registered modular add/subtract of the column with freeze/dir/step inputs, updated on frame end.

Test Plan:
- Reset, then enable=1 with LINES=4, PIC_W_BYTE=128, HEAD=0, column=0, ack tied high -> mem_addr 0,128,256,384 at counter 0..3; load_en at counter 1..4 with load_id 0..3; DONE from counter 4.
- Same setup, step_size=3, dir=0 -> frame_sync at counter 255; column 3; next frame addresses 3,131,259,387.
- dir=1, step_size=3, column=1, PIC_COLS=128 -> column becomes 126 after frame end; freeze=1 -> column unchanged.
- LINES=64, ack only every 5th cycle (fetch needs 320 cycles) -> overrun=1 at counter 255; no load_en at counter 0 of the next frame except from new acks; idx restarts at 0; overrun_clr=1 clears the flag.
- enable dropped mid-FETCH at idx=2 -> next cycle mem_req=0, counter=0, no further load_en; re-enable -> fetch restarts at idx 0 with the retained column.
- Assert rst_N=0 asynchronously mid-fetch -> all outputs immediately at reset values; mem_addr=HEAD.
